// File: rtl/board_ctrl_if.sv
// board_ctrl_if: move handshake, debug cell write and display lookup of the
// 2048 board controller.
//   dir_valid/dir/dir_ready : move command handshake (0=up,1=down,2=left,3=right)
//   load_en/load_id/load_type : single-cell write, honoured only while idle
//   BlockID/BlockType       : combinational display lookup, 4*row+col
//   moved/isDead/win        : game status flags
// master = the side issuing moves and lookups; slave = board_ctrl.
interface board_ctrl_if;
  logic       dir_valid;
  logic [1:0] dir;
  logic       dir_ready;
  logic       load_en;
  logic [3:0] load_id;
  logic [3:0] load_type;
  logic [3:0] BlockID;
  logic [3:0] BlockType;
  logic       moved;
  logic       isDead;
  logic       win;

  modport master (
    output dir_valid, dir, load_en, load_id, load_type, BlockID,
    input  dir_ready, BlockType, moved, isDead, win
  );

  modport slave (
    input  dir_valid, dir, load_en, load_id, load_type, BlockID,
    output dir_ready, BlockType, moved, isDead, win
  );
endinterface

// File: rtl/board_ctrl.sv
// board_ctrl: owns the 4x4 board of the 2048 game and sequences each move.
// A move slides/merges one line per cycle (LINE0..LINE3), spawns a tile at
// an LFSR-chosen free cell (SPAWN), then re-evaluates game over (CHECK).
// After reset INIT performs the first spawn, SPAWN the second, then CHECK.
// Ports:
//   clk  : single clock
//   rst  : asynchronous active-low reset (shared with the VGA controller)
//   bus  : board_ctrl_if.slave (handshake, debug write, display lookup, flags)
module board_ctrl #(
  parameter int unsigned MAX_TYPE  = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  board_ctrl_if.slave  bus
);

  typedef logic [3:0] cell_t;
  typedef cell_t [3:0] line_t;   // element 0 is the leading edge of the move

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LINE0, S_LINE1, S_LINE2, S_LINE3, S_SPAWN, S_CHECK
  } state_t;

  localparam cell_t MAX_T = cell_t'(MAX_TYPE);

  state_t      state, state_nxt;
  cell_t       board [16];
  logic [15:0] lfsr;
  logic [1:0]  dir_q;
  logic        changed;
  logic [3:0]  scan_idx;     // next cell to probe after the entry cycle
  logic [3:0]  scan_cnt;     // occupied cells already skipped this spawn
  cell_t       spawn_type;
  logic        moved_q, dead_q, win_q;

  logic        dir_ready;
  logic        accept;

  // Board index of position p (0 = leading edge) of line k for direction d.
  function automatic logic [3:0] cell_index(input logic [1:0] d,
                                            input logic [1:0] k,
                                            input logic [1:0] p);
    logic [1:0] q;
    q = 2'd3 - p;
    case (d)
      2'd0:    cell_index = {p, k};   // up:    col k, row 0..3
      2'd1:    cell_index = {q, k};   // down:  col k, row 3..0
      2'd2:    cell_index = {k, p};   // left:  row k, col 0..3
      default: cell_index = {k, q};   // right: row k, col 3..0
    endcase
  endfunction

  function automatic logic can_merge(input cell_t a, input cell_t b);
    return (a != 4'd0) && (a == b) && (a != MAX_T);
  endfunction

  // Compact toward the leading edge, then merge pairs scanning from it.
  // The explicit pair pattern guarantees each tile merges at most once.
  function automatic line_t slide(input line_t l);
    line_t      c;
    line_t      r;
    logic [2:0] n;
    c = '0;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (l[i] != 4'd0) begin
        c[n[1:0]] = l[i];
        n = n + 3'd1;
      end
    end
    r = '0;
    if (can_merge(c[0], c[1])) begin
      r[0] = c[0] + 4'd1;
      if (can_merge(c[2], c[3])) begin
        r[1] = c[2] + 4'd1;
      end else begin
        r[1] = c[2];
        r[2] = c[3];
      end
    end else begin
      r[0] = c[0];
      if (can_merge(c[1], c[2])) begin
        r[1] = c[1] + 4'd1;
        r[2] = c[3];
      end else begin
        r[1] = c[1];
        if (can_merge(c[2], c[3])) begin
          r[2] = c[2] + 4'd1;
        end else begin
          r[2] = c[2];
          r[3] = c[3];
        end
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Line datapath
  // ---------------------------------------------------------------------
  logic [1:0] line_k;
  logic [3:0] line_idx [4];
  line_t      line_in, line_out;
  logic       line_changed, line_win;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path through the block can infer a latch.
  always_comb begin
    case (state)
      S_LINE1: line_k = 2'd1;
      S_LINE2: line_k = 2'd2;
      S_LINE3: line_k = 2'd3;
      default: line_k = 2'd0;
    endcase
    line_in = '0;
    for (int p = 0; p < 4; p++) begin
      line_idx[p] = cell_index(dir_q, line_k, 2'(p));
      line_in[p]  = board[line_idx[p]];
    end
    line_out     = slide(line_in);
    line_changed = (line_out != line_in);
    line_win     = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (line_out[p] == MAX_T) line_win = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Spawn datapath: the entry cycle (scan_cnt == 0) draws the start cell
  // and tile type from the live LFSR; later cycles walk forward from there.
  // ---------------------------------------------------------------------
  logic [3:0] spawn_idx;
  cell_t      spawn_val;
  logic       spawn_hit, spawn_done;

  always_comb begin
    if (scan_cnt == 4'd0) begin
      spawn_idx = lfsr[3:0];
      spawn_val = (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
    end else begin
      spawn_idx = scan_idx;
      spawn_val = spawn_type;
    end
    spawn_hit  = (board[spawn_idx] == 4'd0);
    spawn_done = spawn_hit || (scan_cnt == 4'd15);
  end

  // ---------------------------------------------------------------------
  // Game-over detection: no empty cell and no equal orthogonal neighbours.
  // ---------------------------------------------------------------------
  logic dead;

  always_comb begin
    dead = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (board[4'(i)] == 4'd0) dead = 1'b0;
      if ((i % 4) != 3 && board[4'(i)] == board[4'(i + 1)]) dead = 1'b0;
      if (i < 12 && board[4'(i)] == board[4'(i + 4)]) dead = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  assign dir_ready = (state == S_IDLE) && !dead_q;
  assign accept    = dir_ready && bus.dir_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (spawn_done) state_nxt = S_SPAWN;
      S_IDLE:  if (accept) state_nxt = S_LINE0;
      S_LINE0: state_nxt = S_LINE1;
      S_LINE1: state_nxt = S_LINE2;
      S_LINE2: state_nxt = S_LINE3;
      S_LINE3: state_nxt = (changed || line_changed) ? S_SPAWN : S_CHECK;
      S_SPAWN: if (spawn_done) state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_INIT;
      lfsr       <= LFSR_SEED;
      dir_q      <= 2'd0;
      changed    <= 1'b0;
      scan_idx   <= 4'd0;
      scan_cnt   <= 4'd0;
      spawn_type <= 4'd0;
      moved_q    <= 1'b0;
      dead_q     <= 1'b0;
      win_q      <= 1'b0;
      // NOTE: the board is 16 discrete flops, not a RAM, so clearing it in
      // the asynchronous reset is legal and is what a restart requires.
      for (int i = 0; i < 16; i++) board[i] <= 4'd0;
    end else begin
      state <= state_nxt;
      lfsr  <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

      case (state)
        S_IDLE: begin
          if (accept) begin
            dir_q   <= bus.dir;
            changed <= 1'b0;
          end else if (bus.load_en) begin
            board[bus.load_id] <= bus.load_type;
          end
        end

        S_LINE0, S_LINE1, S_LINE2, S_LINE3: begin
          for (int p = 0; p < 4; p++) board[line_idx[p]] <= line_out[p];
          changed <= changed | line_changed;
          if (line_win) win_q <= 1'b1;
          if (state == S_LINE3) moved_q <= changed | line_changed;
        end

        S_INIT, S_SPAWN: begin
          if (spawn_hit) board[spawn_idx] <= spawn_val;
          if (scan_cnt == 4'd0) spawn_type <= spawn_val;
          if (spawn_done) begin
            scan_cnt <= 4'd0;
          end else begin
            scan_cnt <= scan_cnt + 4'd1;
            scan_idx <= spawn_idx + 4'd1;
          end
        end

        S_CHECK: if (dead) dead_q <= 1'b1;

        default: ;
      endcase
    end
  end

  assign bus.dir_ready = dir_ready;
  assign bus.BlockType = board[bus.BlockID];
  assign bus.moved     = moved_q;
  assign bus.isDead    = dead_q;
  assign bus.win       = win_q;

endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl: directed self-checking bench for board_ctrl.
// Boards are written as 64-bit vectors with cell 0 in the top nibble, so a
// hex constant reads row-major: 64'h1111_0000_0000_0000 is row 0 = [1,1,1,1].
module tb_board_ctrl;

  localparam logic [15:0] SEED        = 16'hACE1;
  localparam int          MOVE_BUDGET = 40;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [15:0] ref_lfsr;

  board_ctrl_if bus ();

  board_ctrl #(
    .MAX_TYPE  (10),
    .LFSR_SEED (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ref_lfsr <= SEED;
    else      ref_lfsr <= {ref_lfsr[0] ^ ref_lfsr[2] ^ ref_lfsr[3] ^ ref_lfsr[5],
                           ref_lfsr[15:1]};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------
  // Stimulus helpers (no comparisons in here)
  // ------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_board(output logic [63:0] b);
    b = '0;
    for (int i = 0; i < 16; i++) begin
      bus.BlockID = 4'(i);
      #1;
      b[63 - 4*i -: 4] = bus.BlockType;
    end
  endtask

  task automatic load_board(input logic [63:0] b);
    step();
    for (int i = 0; i < 16; i++) begin
      bus.load_en   = 1'b1;
      bus.load_id   = 4'(i);
      bus.load_type = b[63 - 4*i -: 4];
      step();
    end
    bus.load_en = 1'b0;
  endtask

  // Issue one move; lat = edges after E until dir_ready is seen (-1 if the
  // budget expires); snap = LFSR value during the cycle after E+4.
  task automatic do_move(input logic [1:0] d, output int lat, output logic [15:0] snap);
    lat  = -1;
    snap = '0;
    step();
    bus.dir       = d;
    bus.dir_valid = 1'b1;
    step();
    bus.dir_valid = 1'b0;
    for (int n = 1; n <= MOVE_BUDGET; n++) begin
      step();
      if (n == 4) snap = ref_lfsr;
      if (bus.dir_ready) begin
        lat = n;
        break;
      end
    end
  endtask

  // Spawn model: probe from l[3:0] upward, type 2 if l[7:4]==0 else 1.
  function automatic logic [63:0] spawn_model(input logic [63:0] b,
                                              input logic [15:0] l,
                                              output int skipped);
    logic [63:0] r;
    logic [3:0]  s;
    logic [3:0]  t;
    r       = b;
    s       = l[3:0];
    t       = (l[7:4] == 4'd0) ? 4'd2 : 4'd1;
    skipped = 0;
    for (int i = 0; i < 16; i++) begin
      if (r[63 - 4*s -: 4] == 4'd0) begin
        r[63 - 4*s -: 4] = t;
        return r;
      end
      s = s + 4'd1;
      if (i < 15) skipped++;
    end
    return r;
  endfunction

  // ------------------------------------------------------------------
  // Tests
  // ------------------------------------------------------------------
  task automatic test_reset();
    logic [63:0] b;
    int          n;
    rst = 1'b0;
    step();
    step();
    checks++;
    if (bus.dir_ready !== 1'b0) begin
      failures++; $display("FAIL reset_dir_ready got=%b want=0", bus.dir_ready);
    end
    checks++;
    if ({bus.moved, bus.isDead, bus.win} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b want=000", {bus.moved, bus.isDead, bus.win});
    end
    read_board(b);
    checks++;
    if (b !== 64'h0) begin
      failures++; $display("FAIL reset_board got=%h want=0", b);
    end
    step();
    rst = 1'b1;
    n   = -1;
    for (int i = 1; i <= MOVE_BUDGET; i++) begin
      step();
      if (bus.dir_ready) begin n = i; break; end
    end
    checks++;
    if (n !== 3) begin
      failures++; $display("FAIL init_ready_latency got=%0d want=3", n);
    end
    read_board(b);
    // Seed ACE1: INIT probes cell 1 (type 1), next LFSR 5670 probes cell 0.
    checks++;
    if (b !== 64'h1100_0000_0000_0000) begin
      failures++; $display("FAIL init_spawn_board got=%h want=1100000000000000", b);
    end
    checks++;
    if (bus.isDead !== 1'b0) begin
      failures++; $display("FAIL init_isDead got=%b want=0", bus.isDead);
    end
  endtask

  task automatic test_slide_merge();
    logic [63:0] b, exp_b;
    logic [15:0] snap;
    int          lat, k;
    load_board(64'h1111_0000_0000_0000);
    do_move(2'd2, lat, snap);
    exp_b = spawn_model(64'h2200_0000_0000_0000, snap, k);
    checks++;
    if (lat !== 6 + k) begin
      failures++; $display("FAIL merge_row_latency got=%0d want=%0d", lat, 6 + k);
    end
    checks++;
    if (bus.moved !== 1'b1) begin
      failures++; $display("FAIL merge_row_moved got=%b want=1", bus.moved);
    end
    read_board(b);
    checks++;
    if (b !== exp_b) begin
      failures++; $display("FAIL merge_row_board got=%h want=%h", b, exp_b);
    end
  endtask

  task automatic test_merge_once();
    logic [63:0] b, exp_b;
    logic [15:0] snap;
    int          lat, k;
    load_board(64'h1120_0000_0000_0000);
    do_move(2'd2, lat, snap);
    exp_b = spawn_model(64'h2200_0000_0000_0000, snap, k);
    read_board(b);
    checks++;
    if (b !== exp_b) begin
      failures++; $display("FAIL merge_once_left got=%h want=%h", b, exp_b);
    end
    checks++;
    if (lat !== 6 + k) begin
      failures++; $display("FAIL merge_once_left_latency got=%0d want=%0d", lat, 6 + k);
    end
    // Col 0 rows 0..3 = [2,0,2,2], down -> [0,0,2,3].
    load_board(64'h2000_0000_2000_2000);
    do_move(2'd1, lat, snap);
    exp_b = spawn_model(64'h0000_0000_2000_3000, snap, k);
    read_board(b);
    checks++;
    if (b !== exp_b) begin
      failures++; $display("FAIL merge_once_down got=%h want=%h", b, exp_b);
    end
    checks++;
    if (lat !== 6 + k) begin
      failures++; $display("FAIL merge_once_down_latency got=%0d want=%0d", lat, 6 + k);
    end
  endtask

  task automatic test_no_move();
    logic [63:0] b;
    logic [15:0] snap;
    int          lat;
    load_board(64'h1234_0000_0000_0000);
    do_move(2'd2, lat, snap);
    checks++;
    if (lat !== 5) begin
      failures++; $display("FAIL no_move_latency got=%0d want=5", lat);
    end
    checks++;
    if (bus.moved !== 1'b0) begin
      failures++; $display("FAIL no_move_moved got=%b want=0", bus.moved);
    end
    read_board(b);
    checks++;
    if (b !== 64'h1234_0000_0000_0000) begin
      failures++; $display("FAIL no_move_board got=%h want=1234000000000000", b);
    end
  endtask

  task automatic test_win();
    logic [63:0] b, exp_b;
    logic [15:0] snap;
    int          lat, k;
    checks++;
    if (bus.win !== 1'b0) begin
      failures++; $display("FAIL win_before got=%b want=0", bus.win);
    end
    load_board(64'h9900_0000_0000_0000);
    do_move(2'd2, lat, snap);
    exp_b = spawn_model(64'hA000_0000_0000_0000, snap, k);
    checks++;
    if (bus.win !== 1'b1) begin
      failures++; $display("FAIL win_set got=%b want=1", bus.win);
    end
    read_board(b);
    checks++;
    if (b !== exp_b) begin
      failures++; $display("FAIL win_board got=%h want=%h", b, exp_b);
    end
    load_board(64'hAA00_0000_0000_0000);
    do_move(2'd2, lat, snap);
    read_board(b);
    checks++;
    if (b !== 64'hAA00_0000_0000_0000) begin
      failures++; $display("FAIL max_no_merge_board got=%h want=aa00000000000000", b);
    end
    checks++;
    if ({bus.moved, bus.win} !== 2'b01) begin
      failures++; $display("FAIL max_no_merge_flags got=%b want=01 (moved,win)", {bus.moved, bus.win});
    end
    checks++;
    if (lat !== 5) begin
      failures++; $display("FAIL max_no_merge_latency got=%0d want=5", lat);
    end
  endtask

  task automatic test_reset_mid_move();
    logic [63:0] b, exp_b;
    logic [15:0] snap0, snap1;
    int          n, k0, k1;
    load_board(64'h1100_2200_0000_0000);
    step();
    bus.dir       = 2'd2;
    bus.dir_valid = 1'b1;
    step();                      // edge E
    bus.dir_valid = 1'b0;
    step();                      // E+1: LINE1
    step();                      // E+2: LINE2
    rst = 1'b0;
    #1;
    read_board(b);
    checks++;
    if (b !== 64'h0) begin
      failures++; $display("FAIL mid_reset_board got=%h want=0", b);
    end
    checks++;
    if ({bus.dir_ready, bus.moved, bus.isDead, bus.win} !== 4'b0000) begin
      failures++; $display("FAIL mid_reset_flags got=%b want=0000", {bus.dir_ready, bus.moved, bus.isDead, bus.win});
    end
    step();
    snap0 = ref_lfsr;
    snap1 = '0;
    rst   = 1'b1;
    n     = -1;
    for (int i = 1; i <= MOVE_BUDGET; i++) begin
      step();
      if (i == 1) snap1 = ref_lfsr;
      if (bus.dir_ready) begin n = i; break; end
    end
    exp_b = spawn_model(64'h0, snap0, k0);
    exp_b = spawn_model(exp_b, snap1, k1);
    read_board(b);
    checks++;
    if (b !== exp_b) begin
      failures++; $display("FAIL mid_reset_respawn got=%h want=%h", b, exp_b);
    end
    checks++;
    if (n !== k0 + k1 + 3) begin
      failures++; $display("FAIL mid_reset_ready got=%0d want=%0d", n, k0 + k1 + 3);
    end
  endtask

  task automatic test_dead();
    logic [63:0] b;
    load_board(64'h1212_2121_1212_2121);
    checks++;
    if (bus.isDead !== 1'b0) begin
      failures++; $display("FAIL dead_before got=%b want=0", bus.isDead);
    end
    step();
    bus.dir       = 2'd0;
    bus.dir_valid = 1'b1;
    step();                      // edge E
    bus.dir_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();   // through CHECK at E+5
    checks++;
    if (bus.isDead !== 1'b1) begin
      failures++; $display("FAIL dead_set got=%b want=1", bus.isDead);
    end
    checks++;
    if ({bus.dir_ready, bus.moved} !== 2'b00) begin
      failures++; $display("FAIL dead_ready_moved got=%b want=00", {bus.dir_ready, bus.moved});
    end
    bus.dir       = 2'd3;
    bus.dir_valid = 1'b1;
    for (int i = 0; i < 20; i++) step();
    bus.dir_valid = 1'b0;
    checks++;
    if (bus.dir_ready !== 1'b0) begin
      failures++; $display("FAIL dead_ready_stays got=%b want=0", bus.dir_ready);
    end
    read_board(b);
    checks++;
    if (b !== 64'h1212_2121_1212_2121) begin
      failures++; $display("FAIL dead_board got=%h want=1212212112122121", b);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    bus.dir_valid = 1'b0;
    bus.dir       = 2'd0;
    bus.load_en   = 1'b0;
    bus.load_id   = 4'd0;
    bus.load_type = 4'd0;
    bus.BlockID   = 4'd0;

    test_reset();
    test_slide_merge();
    test_merge_once();
    test_no_move();
    test_win();
    test_reset_mid_move();
    test_dead();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_ctrl.md
# board_ctrl

Owns the 4x4 game board of the 2048 design and sequences every move on it. Accepts a direction command, slides and merges the four lines one per cycle, spawns a new tile from a free-running LFSR, then recomputes the game-over and win flags. Serves the display's per-pixel tile lookup (`BlockID` → `BlockType`) combinationally, in every state, and never stalls it.

## Interface
- `MAX_TYPE`, default 10: highest tile type (10 = 1024). Two `MAX_TYPE` tiles do not merge.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk` in 1: the block's single clock.
- `rst` in 1: reset, asynchronous and active-low, shared with the VGA controller.
- `dir_valid` in 1: a move is requested.
- `dir` in 2: move direction; 0=up, 1=down, 2=left, 3=right.
- `dir_ready` out 1: the block accepts a move.
- `load_en` in 1: debug/bench cell write; honoured only in IDLE and lower priority than `dir_valid`.
- `load_id` in 4: cell index for the debug write.
- `load_type` in 4: tile type for the debug write.
- `BlockID` in 4: display read index, 4*row+col; row 0 is the top row, col 0 is the left column.
- `BlockType` out 4: tile type of cell `BlockID`, 0=empty, combinational.
- `moved` out 1: the last completed move changed the board.
- `isDead` out 1: no legal move remains; sticky.
- `win` out 1: a tile of type `MAX_TYPE` exists or has existed; sticky.

## Operation
- Storage: 16 x 4-bit board registers. LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, advances every cycle in every state.
- States:
  - INIT: two spawns are pending.
  - IDLE
  - LINE0..LINE3
  - SPAWN
  - CHECK
- Reset: all cells 0, `isDead`=0, `win`=0, `moved`=0, `dir_ready`=0, LFSR=`LFSR_SEED`, state INIT.
- INIT:
  - Runs SPAWN twice, then CHECK, then IDLE.
  - A reset asserted at any point, including mid-move, aborts everything and restarts INIT.
- IDLE:
  - `dir_ready` = 1 when `isDead`=0, otherwise 0.
  - If `dir_valid`=1 and `dir_ready`=1, latch `dir`, clear the internal changed flag, and go to LINE0.
  - Otherwise, `load_en`=1 writes `load_type` into cell `load_id`.
- LINEk (one cycle each):
  - Read line k, with cells ordered from the leading edge:
    - left: row k, col 0→3
    - right: row k, col 3→0
    - up: col k, row 0→3
    - down: col k, row 3→0
  - Compact nonzero tiles toward the leading edge.
  - Merge equal adjacent pairs scanning from the leading edge. Each tile merges at most once per move.
  - A merged type is t+1. Pairs with t=`MAX_TYPE` are not merged.
  - Write the line back. OR (any cell differs) into the changed flag.
  - Set `win` if any written cell equals `MAX_TYPE`.
- After LINE3:
  - `moved` ← changed flag.
  - Next state is SPAWN if changed, else CHECK.
- SPAWN:
  - At entry, start index s = LFSR[3:0].
  - Each cycle, examine cell s. If it is empty, write the new type and exit; otherwise s ← s+1 mod 16.
  - New type is 2 (tile "4") if LFSR[7:4]==0, else 1.
  - After 16 occupied cells, exit without writing.
  - Exit goes to CHECK, or back to SPAWN for the second INIT spawn.
- CHECK (one cycle):
  - `isDead` ← 1 if there is no empty cell and no horizontally or vertically adjacent equal pair.
  - Then go to IDLE.
- `BlockType` = board[`BlockID`] in all states. Intermediate line writes are visible, which is acceptable.

## Timing
- Handshake: a move is accepted on the rising edge where `dir_valid`=`dir_ready`=1 (edge E). `dir_ready` is 0 from E until the block returns to IDLE.
- `dir_valid` is ignored outside IDLE; there is no queueing.
- Line writes happen on edges E+1..E+4.
- No-move case: CHECK on edge E+5; `dir_ready` is 1 after E+5.
- Move case: SPAWN takes k+1 cycles, where k = occupied cells skipped (0..15). Latency is 6+k cycles to `dir_ready`.
- `moved` updates at E+4. `isDead` updates at the CHECK edge. `win` updates on the line-write edge.
- After reset release, the first `dir_ready`=1 comes after 2 SPAWN phases plus 1 CHECK cycle (minimum 3 cycles).
- `BlockType` has zero latency from `BlockID` (pure mux).

## Test plan
- Row 0 loaded as [1,1,1,1], rest empty, left → row 0 = [2,2,0,0]; `moved`=1; exactly one new cell of type 1 or 2 in a previously empty cell; `dir_ready` returns at E+6+k.
- Row 0 = [1,1,2,0], left → [2,2,0,0], not [3,0,0,0]. Col 0 = [2,0,2,2] (rows 0..3), down → col 0 rows 0..3 = [0,0,2,3].
- Board with row 0 = [1,2,3,4], rest empty, left → board unchanged; `moved`=0; no spawn; `dir_ready`=1 after E+5.
- Full checkerboard of types 1/2, any direction → `moved`=0; `isDead`=1 after CHECK; `dir_ready` stays 0 until reset.
- Row 0 = [9,9,0,0], left → [10,0,0,0], `win`=1. Then row 0 = [10,10,0,0], left → unchanged, `moved`=0, `win` stays 1.
- Assert `rst` during LINE2 → all cells read 0 immediately; after release, exactly 2 nonzero cells of type 1 or 2, matching the LFSR reference model from `LFSR_SEED`.
